pwm_duty_driver: RTL and testbench
==================================

// Module: pwm_duty_driver
// PURPOSE
//  Digital stage directly upstream of the mixed-signal block's PWM input (pwmin).
//  Turns an 8-bit duty code into a period-aligned PWM waveform for the analog side.
//  Duty updates use a valid/ready handshake and go into a shadow register.
//  A new duty takes effect only at a period boundary, so no period is ever truncated.
// PARAMETERS
//  WIDTH     8  duty/counter width; period = 2**WIDTH ticks, matching the 8-bit DAC/ADC codes
//  PRESCALE  1  clock cycles per counter tick (>=1); period = PRESCALE*2**WIDTH clk cycles
// PORTS
//  clk           input   1      sole clock; all state on rising edge
//  rst           input   1      asynchronous, active-high reset
//  en            input   1      run request (level)
//  duty_in       input   WIDTH  requested duty code; high for duty_in ticks per period
//  duty_valid    input   1      duty_in valid
//  duty_ready    output  1      shadow slot free; == !pend
//  pwm_out       output  1      PWM waveform, drives pwmin of the analog block
//  period_start  output  1      1-cycle pulse in the first clk of every period
//  duty_active   output  WIDTH  duty code currently applied
//  busy          output  1      state != IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; cnt, pre, duty_active, shadow, period_start = 0; pend=0.
//   - pwm_out=0, busy=0, duty_ready=1.
//   - Takes effect mid-period without a clock edge.
//  Prescaler and counter:
//   - pre counts 0..PRESCALE-1; tick = (pre==PRESCALE-1).
//   - cnt += 1 on tick, wrapping 2**WIDTH-1 -> 0; the wrap tick is the period boundary.
//   - In IDLE, pre and cnt are held at 0.
//  Output:
//   - pwm_out = busy && (cnt < duty_active), decoded from registers only (no input paths).
//   - duty=0: output constantly 0. duty=2**WIDTH-1: output low for exactly one tick per period.
//  Handshake:
//   - Transfer occurs on an edge where duty_valid && duty_ready.
//   - IDLE: duty_active <= duty_in directly; pend stays 0.
//   - RUN/DRAIN: shadow <= duty_in, pend <= 1, so ready drops the next cycle.
//   - At a boundary with pend=1 (pre-edge value): duty_active <= shadow, pend <= 0.
//   - Transfer on the same edge as a boundary: boundary sees pend=0, so the new value
//     applies at the following boundary.
//   - duty_in is ignored when duty_valid is low or duty_ready is low.
//  FSM:
//   - IDLE->RUN when en=1: cnt=0, pre=0, period_start=1 in the next cycle.
//     pwm_out follows duty_active from that cycle.
//   - RUN->DRAIN when en=0: counting and pwm_out continue unchanged.
//   - DRAIN->IDLE on the wrap tick; pwm_out=0 from the next cycle. No partial period.
//   - DRAIN->RUN if en=1 again: no restart, cnt continues.
//   - period_start is registered, high for the first clk with cnt=0 after IDLE->RUN and
//     after each wrap while RUN. Not pulsed on DRAIN->IDLE.
// TESTING
//  1. PRESCALE=1, duty 64, en=1 -> pwm high 64 / low 192 clk; period_start every 256 clk.
//  2. Duty 0 -> pwm_out never 1. Duty 255 -> pwm low exactly 1 clk per 256.
//  3. Running at 64, write 192 at cnt=100 -> duty_ready=0.
//     Current period stays 64 high; next period 192 high; ready=1 after the boundary.
//  4. Write accepted on the wrap edge -> next period still old duty;
//     new duty in the period after; ready stays 0 until then.
//  5. en=0 at cnt=10 -> counting continues to 255, then busy=0, pwm_out=0, cnt=0.
//     en re-raised at cnt=200 in DRAIN -> no restart.
//  6. rst raised mid-high-phase between clock edges -> pwm_out, busy=0 immediately.
//     PRESCALE=4 run -> period 1024 clk, high for 4*duty clk.

Source files
------------

// File: rtl/pwm_duty_driver_if.sv
// Duty-update handshake and PWM status bundle for pwm_duty_driver.
interface pwm_duty_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;
  logic             pwm_out;
  logic             period_start;
  logic [WIDTH-1:0] duty_active;
  logic             busy;

  modport master (
    output en, duty_in, duty_valid,
    input  duty_ready, pwm_out, period_start, duty_active, busy
  );

  modport slave (
    input  en, duty_in, duty_valid,
    output duty_ready, pwm_out, period_start, duty_active, busy
  );
endinterface

// File: rtl/pwm_duty_driver.sv
// Period-aligned PWM generator feeding the analog pwmin pin; duty updates are
// staged in a shadow register and applied only at a period boundary.
module pwm_duty_driver #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  pwm_duty_driver_if.slave   bus
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   duty_q, duty_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic               pend_q, pend_d;
  logic               pstart_q, pstart_d;
  logic               tick, wrap, xfer;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pstart_q <= pstart_d;
    end
  end

  // Next-state, counters and duty handshake
  always_comb begin
    tick     = (pre_q == PRE_W'(PRESCALE - 1));
    wrap     = tick && (cnt_q == '1);
    xfer     = bus.duty_valid && !pend_q;
    state_d  = state_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pstart_d = 1'b0;

    case (state_q)
      IDLE: begin
        pre_d = '0;
        cnt_d = '0;
        if (xfer) duty_d = bus.duty_in;
        if (bus.en) begin
          state_d  = RUN;
          pstart_d = 1'b1;
        end
      end
      RUN, DRAIN: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        cnt_d = tick ? cnt_q + WIDTH'(1) : cnt_q;
        if (xfer) begin
          shadow_d = bus.duty_in;
          pend_d   = 1'b1;
        end
        // pend is pre-edge, so a write landing on the boundary waits a period
        if (wrap && pend_q) begin
          duty_d = shadow_q;
          pend_d = 1'b0;
        end
        if (state_q == RUN) begin
          if (!bus.en) state_d = DRAIN;
        end else if (bus.en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
        pstart_d = wrap && (state_d != IDLE);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.duty_ready   = !pend_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.pwm_out      = (state_q != IDLE) && (cnt_q < duty_q);
  assign bus.period_start = pstart_q;
  assign bus.duty_active  = duty_q;

endmodule

// File: tb/tb_pwm_duty_driver.sv
// Directed bench for pwm_duty_driver: one PRESCALE=1 and one PRESCALE=4 instance.
module tb_pwm_duty_driver;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   hi;
  int   ps;

  pwm_duty_driver_if #(.WIDTH(8)) if0 ();
  pwm_duty_driver_if #(.WIDTH(8)) if4 ();

  pwm_duty_driver #(.WIDTH(8), .PRESCALE(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  pwm_duty_driver #(.WIDTH(8), .PRESCALE(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples n consecutive negedges, the current one first
  task automatic meas(input int n, input bit sel, output int h, output int p);
    h = 0;
    p = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (sel) begin
        h += int'(if4.pwm_out);
        p += int'(if4.period_start);
      end else begin
        h += int'(if0.pwm_out);
        p += int'(if0.period_start);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    if0.en = 1'b0; if0.duty_in = '0; if0.duty_valid = 1'b0;
    if4.en = 1'b0; if4.duty_in = '0; if4.duty_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm",    32'(if0.pwm_out), 0);
    check("rst_busy",   32'(if0.busy), 0);
    check("rst_ready",  32'(if0.duty_ready), 1);
    check("rst_duty",   32'(if0.duty_active), 0);
    check("rst_pstart", 32'(if0.period_start), 0);
    rst = 1'b0;

    // Duty 64 loaded in IDLE, then run
    @(negedge clk);
    if0.duty_in = 8'd64; if0.duty_valid = 1'b1; if0.en = 1'b1;
    @(negedge clk);
    if0.duty_valid = 1'b0;
    check("start_pstart", 32'(if0.period_start), 1);
    check("start_busy",   32'(if0.busy), 1);
    check("start_pwm",    32'(if0.pwm_out), 1);
    check("start_duty",   32'(if0.duty_active), 64);
    meas(512, 1'b0, hi, ps);
    check("d64_high", 32'(hi), 128);
    check("d64_pstarts", 32'(ps), 2);

    // Mid-period write of 192 at cnt=100
    repeat (101) @(negedge clk);
    if0.duty_in = 8'd192; if0.duty_valid = 1'b1;
    @(negedge clk);
    if0.duty_valid = 1'b0;
    check("mid_ready_low", 32'(if0.duty_ready), 0);
    check("mid_duty_old",  32'(if0.duty_active), 64);
    meas(155, 1'b0, hi, ps);
    check("mid_tail_high", 32'(hi), 0);
    check("mid_ready_end", 32'(if0.duty_ready), 0);
    @(negedge clk);
    check("mid_duty_new",  32'(if0.duty_active), 192);
    check("mid_ready_back", 32'(if0.duty_ready), 1);
    check("mid_pstart",    32'(if0.period_start), 1);
    meas(256, 1'b0, hi, ps);
    check("d192_high", 32'(hi), 192);

    // Write accepted on the wrap edge waits one extra period
    if0.duty_in = 8'd32; if0.duty_valid = 1'b1;
    @(negedge clk);
    if0.duty_valid = 1'b0;
    check("wrap_duty_old", 32'(if0.duty_active), 192);
    check("wrap_ready",    32'(if0.duty_ready), 0);
    meas(256, 1'b0, hi, ps);
    check("wrap_old_high", 32'(hi), 192);
    check("wrap_ready_end", 32'(if0.duty_ready), 0);
    @(negedge clk);
    check("wrap_duty_new", 32'(if0.duty_active), 32);
    check("wrap_ready_back", 32'(if0.duty_ready), 1);
    meas(256, 1'b0, hi, ps);
    check("d32_high", 32'(hi), 32);
    check("d32_pstarts", 32'(ps), 1);

    // Duty 0 never drives high
    @(negedge clk);
    if0.duty_in = 8'd0; if0.duty_valid = 1'b1;
    @(negedge clk);
    if0.duty_valid = 1'b0;
    repeat (255) @(negedge clk);
    check("d0_duty", 32'(if0.duty_active), 0);
    meas(256, 1'b0, hi, ps);
    check("d0_high", 32'(hi), 0);

    // Duty 255 low exactly once per period
    @(negedge clk);
    if0.duty_in = 8'd255; if0.duty_valid = 1'b1;
    @(negedge clk);
    if0.duty_valid = 1'b0;
    repeat (255) @(negedge clk);
    check("d255_duty", 32'(if0.duty_active), 255);
    meas(512, 1'b0, hi, ps);
    check("d255_high", 32'(hi), 510);
    check("d255_last_low", 32'(if0.pwm_out), 0);

    // Drain: en dropped at cnt=10, runs out the period
    repeat (11) @(negedge clk);
    if0.en = 1'b0;
    @(negedge clk);
    check("drain_busy", 32'(if0.busy), 1);
    check("drain_pwm",  32'(if0.pwm_out), 1);
    repeat (244) @(negedge clk);
    check("drain_end_busy", 32'(if0.busy), 1);
    @(negedge clk);
    check("idle_busy",   32'(if0.busy), 0);
    check("idle_pwm",    32'(if0.pwm_out), 0);
    check("idle_pstart", 32'(if0.period_start), 0);

    // Re-raise en at cnt=200 in DRAIN: no restart
    if0.en = 1'b1;
    @(negedge clk);
    check("rerun_pstart", 32'(if0.period_start), 1);
    if0.en = 1'b0;
    repeat (200) @(negedge clk);
    check("rerun_drain_busy", 32'(if0.busy), 1);
    if0.en = 1'b1;
    @(negedge clk);
    check("norestart_pstart", 32'(if0.period_start), 0);
    check("norestart_pwm",    32'(if0.pwm_out), 1);
    repeat (55) @(negedge clk);
    check("norestart_wrap_pstart", 32'(if0.period_start), 1);
    check("norestart_wrap_busy",   32'(if0.busy), 1);

    // Asynchronous reset in the middle of a high phase
    check("pre_rst_pwm", 32'(if0.pwm_out), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pwm",   32'(if0.pwm_out), 0);
    check("async_rst_busy",  32'(if0.busy), 0);
    check("async_rst_ready", 32'(if0.duty_ready), 1);
    check("async_rst_duty",  32'(if0.duty_active), 0);
    if0.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // PRESCALE=4: 1024-clk period, duty 100 -> 400 clk high
    @(negedge clk);
    if4.duty_in = 8'd100; if4.duty_valid = 1'b1; if4.en = 1'b1;
    @(negedge clk);
    if4.duty_valid = 1'b0;
    check("p4_pstart", 32'(if4.period_start), 1);
    check("p4_duty",   32'(if4.duty_active), 100);
    meas(1024, 1'b1, hi, ps);
    check("p4_high",    32'(hi), 400);
    check("p4_pstarts", 32'(ps), 1);
    @(negedge clk);
    check("p4_next_pstart", 32'(if4.period_start), 1);
    check("p4_next_pwm",    32'(if4.pwm_out), 1);
    check("p4_u0_idle",     32'(if0.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
